// File: rtl/mem_bus_rr_arbiter.sv
// Round-robin arbiter that lets NPORTS cache controllers share one main-memory model.
// One access is in flight at a time. Each access takes a fixed latency and ends with a per-port completion pulse.
module mem_bus_rr_arbiter #(
    parameter int NPORTS    = 2,
    parameter int ADDRWIDTH = 16,
    parameter int WORDWIDTH = 16,
    parameter int MEMWORDS  = 65536,
    parameter int RD_LAT    = 100,
    parameter int WT_LAT    = 100,
    localparam int GW = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [2*NPORTS-1:0]           rw_req,
    input  logic [ADDRWIDTH*NPORTS-1:0]   addr_in,
    input  logic [WORDWIDTH*NPORTS-1:0]   wdata_in,
    output logic [WORDWIDTH*NPORTS-1:0]   rdata_out,
    output logic [NPORTS-1:0]             rd_en,
    output logic [NPORTS-1:0]             wb_done,
    output logic                          busy,
    output logic [GW-1:0]                 grant_id,
    output logic [1:0]                    err
);

    localparam int MAW    = (MEMWORDS > 1) ? $clog2(MEMWORDS) : 1;
    localparam int MAXLAT = (RD_LAT > WT_LAT) ? RD_LAT : WT_LAT;
    localparam int CW     = (MAXLAT > 1) ? $clog2(MAXLAT) : 1;

    localparam logic [1:0] OP_RD  = 2'd1;
    localparam logic [1:0] OP_WT  = 2'd2;
    localparam logic [1:0] OP_ILL = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t                 state_reg, state_next;
    logic [GW-1:0]          ptr_reg, ptr_next;
    logic [GW-1:0]          grant_reg, grant_next;
    logic                   wr_reg, wr_next;
    logic [MAW-1:0]         addr_reg, addr_next;
    logic [WORDWIDTH-1:0]   wdata_reg, wdata_next;
    logic [CW-1:0]          cnt_reg, cnt_next;
    logic                   busy_reg, busy_next;
    logic [1:0]             err_reg, err_next;
    logic [NPORTS-1:0]      rd_en_reg, rd_en_next;
    logic [NPORTS-1:0]      wb_done_reg, wb_done_next;
    logic                   rd_fire, wt_fire, mem_we;

    logic [1:0]             op_p      [NPORTS];
    logic [ADDRWIDTH-1:0]   addr_p    [NPORTS];
    logic [WORDWIDTH-1:0]   wdata_p   [NPORTS];
    logic [WORDWIDTH-1:0]   rdata_reg [NPORTS];
    logic [NPORTS-1:0]      eligible, illegal, out_of_range;

    logic                   pick_valid;
    logic [GW-1:0]          pick_id;
    logic [GW-1:0]          idx;

    logic [WORDWIDTH-1:0]   mem [MEMWORDS];

    // Per-port unpacking and request classification.
    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
            assign op_p[gi]    = rw_req[2*gi +: 2];
            assign addr_p[gi]  = addr_in[ADDRWIDTH*gi +: ADDRWIDTH];
            assign wdata_p[gi] = wdata_in[WORDWIDTH*gi +: WORDWIDTH];

            assign illegal[gi]      = (op_p[gi] == OP_ILL);
            assign out_of_range[gi] = ((op_p[gi] == OP_RD) || (op_p[gi] == OP_WT)) &&
                                      (64'(addr_p[gi]) >= 64'(MEMWORDS));
            assign eligible[gi]     = ((op_p[gi] == OP_RD) || (op_p[gi] == OP_WT)) &&
                                      !out_of_range[gi];

            assign rdata_out[WORDWIDTH*gi +: WORDWIDTH] = rdata_reg[gi];
        end
    endgenerate

    // Round-robin search: walk from ptr upward and wrap at NPORTS.
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        idx        = ptr_reg;
        for (int i = 0; i < NPORTS; i++) begin
            if (!pick_valid && eligible[idx]) begin
                pick_valid = 1'b1;
                pick_id    = idx;
            end
            idx = (idx == GW'(NPORTS - 1)) ? '0 : idx + GW'(1);
        end
    end

    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        grant_next   = grant_reg;
        wr_next      = wr_reg;
        addr_next    = addr_reg;
        wdata_next   = wdata_reg;
        cnt_next     = cnt_reg;
        busy_next    = busy_reg;
        err_next     = err_reg;
        rd_en_next   = '0;
        wb_done_next = '0;
        rd_fire      = 1'b0;
        wt_fire      = 1'b0;

        case (state_reg)
            S_IDLE: begin
                err_next = err_reg | {|out_of_range, |illegal};
                if (pick_valid) begin
                    state_next = S_ACCESS;
                    grant_next = pick_id;
                    wr_next    = (op_p[pick_id] == OP_WT);
                    addr_next  = addr_p[pick_id][MAW-1:0];
                    wdata_next = wdata_p[pick_id];
                    cnt_next   = (op_p[pick_id] == OP_WT) ? CW'(WT_LAT - 1) : CW'(RD_LAT - 1);
                    busy_next  = 1'b1;
                    ptr_next   = (pick_id == GW'(NPORTS - 1)) ? '0 : pick_id + GW'(1);
                end
            end
            S_ACCESS: begin
                if (cnt_reg == '0) begin
                    state_next = S_RESP;
                    if (wr_reg) begin
                        wt_fire                 = 1'b1;
                        wb_done_next[grant_reg] = 1'b1;
                    end else begin
                        rd_fire               = 1'b1;
                        rd_en_next[grant_reg] = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            S_RESP: begin
                // Requests are deliberately not sampled here, so the requester can drop rw_req.
                state_next = S_IDLE;
                busy_next  = 1'b0;
            end
            default: begin
                state_next = S_IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            ptr_reg     <= '0;
            grant_reg   <= '0;
            wr_reg      <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            cnt_reg     <= '0;
            busy_reg    <= 1'b0;
            err_reg     <= '0;
            rd_en_reg   <= '0;
            wb_done_reg <= '0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            grant_reg   <= grant_next;
            wr_reg      <= wr_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
            cnt_reg     <= cnt_next;
            busy_reg    <= busy_next;
            err_reg     <= err_next;
            rd_en_reg   <= rd_en_next;
            wb_done_reg <= wb_done_next;
        end
    end

    // A write still pending when reset arrives is dropped, not committed.
    assign mem_we = wt_fire && !reset;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_reg] <= wdata_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < NPORTS; p++) begin
                rdata_reg[p] <= '0;
            end
        end else if (rd_fire) begin
            rdata_reg[grant_reg] <= mem[addr_reg];
        end
    end

    assign rd_en    = rd_en_reg;
    assign wb_done  = wb_done_reg;
    assign busy     = busy_reg;
    assign grant_id = grant_reg;
    assign err      = err_reg;

endmodule

// File: tb/tb_mem_bus_rr_arbiter.sv
// Bench for mem_bus_rr_arbiter. Two instances are exercised.
// A 4-port instance is checked against a transaction-timeline model, and a 2-port short-latency instance is checked for back-to-back timing.
module tb_mem_bus_rr_arbiter;

    localparam int NP = 4;
    localparam int AW = 10;
    localparam int WW = 16;
    localparam int MW = 768;
    localparam int RL = 4;
    localparam int WL = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance A
    logic                rst_a;
    logic [2*NP-1:0]     rw_req_a;
    logic [AW*NP-1:0]    addr_a;
    logic [WW*NP-1:0]    wdata_a, rdata_a;
    logic [NP-1:0]       rd_en_a, wb_done_a;
    logic                busy_a;
    logic [1:0]          gid_a;
    logic [1:0]          err_a;

    // instance B
    logic                rst_b;
    logic [3:0]          rw_req_b;
    logic [15:0]         addr_b;
    logic [31:0]         wdata_b, rdata_b;
    logic [1:0]          rd_en_b, wb_done_b;
    logic                busy_b;
    logic [0:0]          gid_b;
    logic [1:0]          err_b;

    mem_bus_rr_arbiter #(.NPORTS(NP), .ADDRWIDTH(AW), .WORDWIDTH(WW), .MEMWORDS(MW),
                         .RD_LAT(RL), .WT_LAT(WL)) dut_a (
        .clk(clk), .reset(rst_a), .rw_req(rw_req_a), .addr_in(addr_a), .wdata_in(wdata_a),
        .rdata_out(rdata_a), .rd_en(rd_en_a), .wb_done(wb_done_a), .busy(busy_a),
        .grant_id(gid_a), .err(err_a));

    mem_bus_rr_arbiter #(.NPORTS(2), .ADDRWIDTH(8), .WORDWIDTH(16), .MEMWORDS(256),
                         .RD_LAT(1), .WT_LAT(3)) dut_b (
        .clk(clk), .reset(rst_b), .rw_req(rw_req_b), .addr_in(addr_b), .wdata_in(wdata_b),
        .rdata_out(rdata_b), .rd_en(rd_en_b), .wb_done(wb_done_b), .busy(busy_b),
        .grant_id(gid_b), .err(err_b));

    int errors = 0;
    int checks = 0;
    int ecount = 0;

    // requesters of instance A
    logic [1:0]    req_op    [NP];
    logic [AW-1:0] req_addr  [NP];
    logic [WW-1:0] req_wdata [NP];

    // timeline model of instance A
    int            m_ptr, m_free, m_pulse, m_last_busy, m_grant, m_addr;
    logic          m_wr;
    logic [WW-1:0] m_wdata;
    logic [WW-1:0] m_mem [int];
    logic [WW-1:0] m_rdata [NP];
    bit            m_rknown [NP];
    logic [1:0]    m_err;
    logic [NP-1:0] exp_rd, exp_wb;
    logic          exp_busy;
    logic [WW*NP-1:0] exp_rdata, rmask;

    // One clock edge of instance A: drive, advance the model, wait to the sampling point.
    task automatic tick_a();
        bit found;
        int p;
        for (int q = 0; q < NP; q++) begin
            rw_req_a[2*q +: 2]   = req_op[q];
            addr_a[AW*q +: AW]   = req_addr[q];
            wdata_a[WW*q +: WW]  = req_wdata[q];
        end
        @(posedge clk);
        ecount++;
        exp_rd = '0;
        exp_wb = '0;
        if (rst_a) begin
            m_ptr = 0; m_free = 0; m_pulse = -1; m_last_busy = -1; m_grant = 0; m_err = 2'b00;
            for (int q = 0; q < NP; q++) begin m_rdata[q] = '0; m_rknown[q] = 1'b1; end
        end else begin
            if (ecount == m_pulse) begin
                if (m_wr) begin
                    m_mem[m_addr] = m_wdata;
                    exp_wb[m_grant] = 1'b1;
                end else begin
                    m_rknown[m_grant] = m_mem.exists(m_addr);
                    if (m_mem.exists(m_addr)) m_rdata[m_grant] = m_mem[m_addr];
                    exp_rd[m_grant] = 1'b1;
                end
            end
            if (ecount >= m_free) begin
                for (int q = 0; q < NP; q++) begin
                    if (req_op[q] == 2'd3) m_err[0] = 1'b1;
                    if ((req_op[q] == 2'd1 || req_op[q] == 2'd2) && int'(req_addr[q]) >= MW) m_err[1] = 1'b1;
                end
                found = 1'b0;
                for (int i = 0; i < NP; i++) begin
                    p = (m_ptr + i) % NP;
                    if (!found && (req_op[p] == 2'd1 || req_op[p] == 2'd2) && int'(req_addr[p]) < MW) begin
                        found   = 1'b1;
                        m_grant = p;
                        m_wr    = (req_op[p] == 2'd2);
                        m_addr  = int'(req_addr[p]);
                        m_wdata = req_wdata[p];
                        m_pulse = ecount + (m_wr ? WL : RL);
                        m_last_busy = m_pulse;
                        m_free  = m_pulse + 2;
                        m_ptr   = (p + 1) % NP;
                    end
                end
            end
        end
        exp_busy = (ecount <= m_last_busy);
        for (int q = 0; q < NP; q++) begin
            exp_rdata[WW*q +: WW] = m_rdata[q];
            rmask[WW*q +: WW]     = {WW{m_rknown[q]}};
        end
        @(negedge clk);
        for (int q = 0; q < NP; q++) if (exp_rd[q] || exp_wb[q]) req_op[q] = 2'd0;
    endtask

    task automatic reset_a();
        rst_a = 1'b1;
        for (int q = 0; q < NP; q++) begin req_op[q] = 2'd0; req_addr[q] = '0; req_wdata[q] = '0; end
        tick_a();
        tick_a();
        rst_a = 1'b0;
    endtask

    task automatic test_reset();
        reset_a();
        checks++;
        if (rd_en_a !== '0 || wb_done_a !== '0 || busy_a !== 1'b0 || gid_a !== 2'd0 ||
            err_a !== 2'b00 || rdata_a !== '0) begin
            errors++;
            $display("FAIL reset rd_en=%b wb_done=%b busy=%b gid=%0d err=%b rdata=%h, all required 0",
                     rd_en_a, wb_done_a, busy_a, gid_a, err_a, rdata_a);
        end
    endtask

    task automatic test_write_read();
        int tg = -1, tp = -1;
        reset_a();
        req_op[0] = 2'd2; req_addr[0] = 10'h010; req_wdata[0] = 16'hBEEF;
        for (int c = 0; c < 12; c++) begin
            tick_a();
            checks++;
            if (rd_en_a !== exp_rd || wb_done_a !== exp_wb || busy_a !== exp_busy || gid_a !== 2'(m_grant) ||
                err_a !== m_err || (rdata_a & rmask) !== (exp_rdata & rmask)) begin
                errors++;
                $display("FAIL wr_cycle t=%0d rd_en=%b/%b wb=%b/%b busy=%b/%b gid=%0d/%0d err=%b/%b (got/exp)",
                         ecount, rd_en_a, exp_rd, wb_done_a, exp_wb, busy_a, exp_busy, gid_a, m_grant, err_a, m_err);
            end
            if (busy_a === 1'b1 && tg < 0) tg = ecount;
            if (wb_done_a[0] === 1'b1) tp = ecount;
        end
        checks++;
        if (tg < 0 || tp - tg != WL) begin
            errors++;
            $display("FAIL wr_latency got=%0d required=%0d", tp - tg, WL);
        end
        tg = -1; tp = -1;
        req_op[0] = 2'd1; req_addr[0] = 10'h010;
        for (int c = 0; c < 10; c++) begin
            tick_a();
            checks++;
            if (rd_en_a !== exp_rd || wb_done_a !== exp_wb || busy_a !== exp_busy || gid_a !== 2'(m_grant) ||
                err_a !== m_err || (rdata_a & rmask) !== (exp_rdata & rmask)) begin
                errors++;
                $display("FAIL rd_cycle t=%0d rd_en=%b/%b wb=%b/%b busy=%b/%b rdata=%h/%h (got/exp)",
                         ecount, rd_en_a, exp_rd, wb_done_a, exp_wb, busy_a, exp_busy, rdata_a, exp_rdata);
            end
            if (busy_a === 1'b1 && tg < 0) tg = ecount;
            if (rd_en_a[0] === 1'b1) tp = ecount;
        end
        checks++;
        if (tg < 0 || tp - tg != RL || rdata_a[15:0] !== 16'hBEEF) begin
            errors++;
            $display("FAIL rd_result latency=%0d required=%0d rdata=%h required=beef", tp - tg, RL, rdata_a[15:0]);
        end
    endtask

    task automatic test_simultaneous();
        int order[$];
        logic prev_busy = 1'b0;
        reset_a();
        for (int q = 0; q < 2; q++) begin req_op[q] = 2'd1; req_addr[q] = 10'h010; end
        for (int c = 0; c < 16; c++) begin
            tick_a();
            checks++;
            if (rd_en_a !== exp_rd || wb_done_a !== exp_wb || busy_a !== exp_busy || gid_a !== 2'(m_grant) ||
                err_a !== m_err || (rdata_a & rmask) !== (exp_rdata & rmask)) begin
                errors++;
                $display("FAIL simul_cycle t=%0d rd_en=%b/%b busy=%b/%b gid=%0d/%0d (got/exp)",
                         ecount, rd_en_a, exp_rd, busy_a, exp_busy, gid_a, m_grant);
            end
            if (busy_a === 1'b1 && prev_busy === 1'b0) order.push_back(int'(gid_a));
            prev_busy = busy_a;
        end
        checks++;
        if (order.size() != 2 || order[0] != 0 || order[1] != 1 || rdata_a[31:16] !== 16'hBEEF) begin
            errors++;
            $display("FAIL simul_order grants=%p required='{0,1} rdata1=%h required=beef", order, rdata_a[31:16]);
        end
    endtask

    task automatic test_fairness();
        int order[$];
        logic prev_busy = 1'b0;
        reset_a();
        for (int q = 0; q < NP; q++) begin req_op[q] = 2'd1; req_addr[q] = AW'(q + 40); end
        for (int c = 0; c < 60 && order.size() < 5; c++) begin
            tick_a();
            checks++;
            if (rd_en_a !== exp_rd || wb_done_a !== exp_wb || busy_a !== exp_busy || gid_a !== 2'(m_grant) ||
                err_a !== m_err) begin
                errors++;
                $display("FAIL fair_cycle t=%0d rd_en=%b/%b busy=%b/%b gid=%0d/%0d (got/exp)",
                         ecount, rd_en_a, exp_rd, busy_a, exp_busy, gid_a, m_grant);
            end
            if (busy_a === 1'b1 && prev_busy === 1'b0) order.push_back(int'(gid_a));
            prev_busy = busy_a;
            for (int q = 0; q < NP; q++) req_op[q] = 2'd1;
        end
        checks++;
        if (order.size() != 5 || order[0] != 0 || order[1] != 1 || order[2] != 2 || order[3] != 3 || order[4] != 0) begin
            errors++;
            $display("FAIL fair_order grants=%p required='{0,1,2,3,0}", order);
        end
    endtask

    task automatic test_errors();
        int pulses = 0;
        reset_a();
        req_op[1] = 2'd3; req_addr[1] = 10'h005;
        for (int c = 0; c < 3; c++) tick_a();
        checks++;
        if (err_a !== 2'b01 || err_a !== m_err) begin
            errors++;
            $display("FAIL err_illegal err=%b required=01", err_a);
        end
        req_op[0] = 2'd1; req_addr[0] = AW'(MW);
        for (int c = 0; c < 12; c++) begin
            tick_a();
            if (rd_en_a !== '0 || wb_done_a !== '0 || busy_a !== 1'b0) pulses++;
        end
        checks++;
        if (err_a !== 2'b11 || pulses != 0) begin
            errors++;
            $display("FAIL err_range err=%b required=11 activity_cycles=%0d required=0", err_a, pulses);
        end
        req_op[0] = 2'd0; req_op[1] = 2'd0;
        req_op[2] = 2'd1; req_addr[2] = 10'h010;
        for (int c = 0; c < 10; c++) begin
            tick_a();
            checks++;
            if (rd_en_a !== exp_rd || busy_a !== exp_busy || gid_a !== 2'(m_grant) || err_a !== m_err) begin
                errors++;
                $display("FAIL err_sticky_cycle t=%0d rd_en=%b/%b busy=%b/%b err=%b/%b (got/exp)",
                         ecount, rd_en_a, exp_rd, busy_a, exp_busy, err_a, m_err);
            end
        end
        checks++;
        if (err_a !== 2'b11 || rdata_a[47:32] !== 16'hBEEF) begin
            errors++;
            $display("FAIL err_sticky err=%b required=11 rdata2=%h required=beef", err_a, rdata_a[47:32]);
        end
        reset_a();
        checks++;
        if (err_a !== 2'b00) begin
            errors++;
            $display("FAIL err_clear err=%b required=00", err_a);
        end
    endtask

    task automatic test_reset_abort();
        int seen_wb = 0;
        reset_a();
        req_op[0] = 2'd2; req_addr[0] = 10'h020; req_wdata[0] = 16'h5A5A;
        for (int c = 0; c < 10; c++) tick_a();
        req_op[0] = 2'd2; req_addr[0] = 10'h020; req_wdata[0] = 16'h1234;
        for (int c = 0; c < 3; c++) tick_a();
        rst_a = 1'b1; req_op[0] = 2'd0;
        for (int c = 0; c < 2; c++) begin tick_a(); if (wb_done_a !== '0) seen_wb++; end
        rst_a = 1'b0;
        for (int c = 0; c < 8; c++) begin tick_a(); if (wb_done_a !== '0) seen_wb++; end
        checks++;
        if (seen_wb != 0) begin
            errors++;
            $display("FAIL abort_pulse wb_done_cycles=%0d required=0", seen_wb);
        end
        req_op[0] = 2'd1; req_addr[0] = 10'h020;
        for (int c = 0; c < 8; c++) begin
            tick_a();
            checks++;
            if (rd_en_a !== exp_rd || wb_done_a !== exp_wb || busy_a !== exp_busy ||
                (rdata_a & rmask) !== (exp_rdata & rmask)) begin
                errors++;
                $display("FAIL abort_cycle t=%0d rd_en=%b/%b busy=%b/%b rdata=%h/%h (got/exp)",
                         ecount, rd_en_a, exp_rd, busy_a, exp_busy, rdata_a, exp_rdata);
            end
        end
        checks++;
        if (rdata_a[15:0] !== 16'h5A5A) begin
            errors++;
            $display("FAIL abort_data rdata=%h required=5a5a", rdata_a[15:0]);
        end
    endtask

    task automatic test_random_traffic();
        reset_a();
        for (int c = 0; c < 400; c++) begin
            for (int q = 0; q < NP; q++) begin
                if (req_op[q] == 2'd0 && $urandom_range(0, 9) < 3) begin
                    req_op[q]    = 2'($urandom_range(1, 2));
                    req_addr[q]  = AW'($urandom_range(0, 31));
                    req_wdata[q] = WW'($urandom);
                end
            end
            tick_a();
            checks++;
            if (rd_en_a !== exp_rd || wb_done_a !== exp_wb || busy_a !== exp_busy || gid_a !== 2'(m_grant) ||
                err_a !== m_err || (rdata_a & rmask) !== (exp_rdata & rmask)) begin
                errors++;
                $display("FAIL random_cycle t=%0d rd_en=%b/%b wb=%b/%b busy=%b/%b gid=%0d/%0d rdata=%h/%h (got/exp)",
                         ecount, rd_en_a, exp_rd, wb_done_a, exp_wb, busy_a, exp_busy, gid_a, m_grant,
                         rdata_a & rmask, exp_rdata & rmask);
            end
        end
    endtask

    // Instance B: RD_LAT=1, WT_LAT=3, port 0 issues each op as soon as the previous pulse is seen.
    task automatic test_back_to_back();
        logic [1:0]  ops   [4];
        logic [7:0]  addrs [4];
        logic [15:0] datas [4];
        int k = 0, t = 0, tg = -1, tp = -1;
        logic prev_busy = 1'b0, prev_pulse = 1'b0, pulse;
        ops[0] = 2'd2; addrs[0] = 8'h05; datas[0] = 16'($urandom);
        ops[1] = 2'd1; addrs[1] = 8'h05; datas[1] = datas[0];
        ops[2] = 2'd2; addrs[2] = 8'h09; datas[2] = 16'($urandom);
        ops[3] = 2'd1; addrs[3] = 8'h09; datas[3] = datas[2];
        rst_b = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b0;
        rw_req_b = {2'd0, ops[0]}; addr_b = {8'd0, addrs[0]}; wdata_b = {16'd0, datas[0]};
        while (k < 4 && t < 60) begin
            @(posedge clk);
            t++;
            @(negedge clk);
            pulse = rd_en_b[0] | wb_done_b[0];
            if (busy_b === 1'b1 && prev_busy === 1'b0) begin
                tg = t;
                checks++;
                if ((k == 0 && tg != 1) || (k > 0 && tg - tp != 2)) begin
                    errors++;
                    $display("FAIL b2b_grant op=%0d grant_cycle=%0d prev_pulse=%0d required_gap=2", k, tg, tp);
                end
            end
            if (pulse === 1'b1) begin
                tp = t;
                checks++;
                if (prev_pulse === 1'b1 || busy_b !== 1'b1 || rd_en_b[1] !== 1'b0 || wb_done_b[1] !== 1'b0 ||
                    tp - tg != (ops[k] == 2'd2 ? 3 : 1) || wb_done_b[0] !== (ops[k] == 2'd2) ||
                    (ops[k] == 2'd1 && rdata_b[15:0] !== datas[k])) begin
                    errors++;
                    $display("FAIL b2b_pulse op=%0d latency=%0d required=%0d wb=%b rd=%b rdata=%h required=%h",
                             k, tp - tg, (ops[k] == 2'd2 ? 3 : 1), wb_done_b, rd_en_b, rdata_b[15:0], datas[k]);
                end
                k++;
                if (k < 4) begin
                    rw_req_b = {2'd0, ops[k]}; addr_b = {8'd0, addrs[k]}; wdata_b = {16'd0, datas[k]};
                end else begin
                    rw_req_b = '0;
                end
            end
            prev_busy  = busy_b;
            prev_pulse = pulse;
        end
        checks++;
        if (k != 4) begin
            errors++;
            $display("FAIL b2b_timeout completed=%0d required=4", k);
        end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        rw_req_a = '0; addr_a = '0; wdata_a = '0;
        rw_req_b = '0; addr_b = '0; wdata_b = '0;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_simultaneous();
        test_fairness();
        test_errors();
        test_reset_abort();
        test_random_traffic();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
